// File: rtl/risc_v_mike_alu_issue.sv
// RV32I ALU issue stage: decodes one instruction per beat into ALU operands and control.
// Optional RISC_V_MIKE_ISSUE_SKID_EN adds a one-entry skid buffer behind the output register.
package risc_v_mike_pkg;
  localparam int unsigned DATA_32_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLL = 4'd2,
    ALU_SLT = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SRL = 4'd5,
    ALU_SRA = 4'd6,
    ALU_OR  = 4'd7,
    ALU_AND = 4'd8
  } t_alu_opcode;

  typedef struct packed {
    logic [DATA_32_W-1:0] src_a;
    logic [DATA_32_W-1:0] src_b;
    t_alu_opcode          ctrl;
    logic                 is_signed;
    logic                 is_branch;
    logic [2:0]           funct3;
    logic [DATA_32_W-1:0] pc;
    logic                 illegal;
  } t_issue_beat;
endpackage

module risc_v_mike_alu_issue
  import risc_v_mike_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_32_W-1:0] in_instr,
  input  logic [DATA_32_W-1:0] in_pc,
  input  logic [DATA_32_W-1:0] in_rs1_data,
  input  logic [DATA_32_W-1:0] in_rs2_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_32_W-1:0] alu_src_a,
  output logic [DATA_32_W-1:0] alu_src_b,
  output t_alu_opcode          alu_ctrl,
  output logic                 alu_signed,
  output logic                 out_is_branch,
  output logic [2:0]           out_funct3,
  output logic [DATA_32_W-1:0] out_pc,
  output logic                 out_illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic        unused_rd;
  t_alu_opcode f3_op;
  t_issue_beat dec;
  t_issue_beat out_q;
  logic        out_valid_q;
  logic        load;

  assign opcode    = in_instr[6:0];
  assign f3        = in_instr[14:12];
  assign f7        = in_instr[31:25];
  assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u     = {in_instr[31:12], 12'b0};
  assign unused_rd = ^in_instr[11:7];

  always_comb begin
    f3_op = ALU_ADD;
    case (f3)
      3'b000:  f3_op = ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLT;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  end

  // Start from the illegal encoding; each legal form overwrites every field it owns.
  always_comb begin
    dec           = '0;
    dec.ctrl      = ALU_ADD;
    dec.is_signed = 1'b1;
    dec.illegal   = 1'b1;
    dec.funct3    = f3;
    dec.pc        = in_pc;
    case (opcode)
      7'b0110011: begin
        dec.src_a = in_rs1_data;
        dec.src_b = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, in_rs2_data[4:0]} : in_rs2_data;
        if (f7 == 7'b0000000) begin
          dec.ctrl    = f3_op;
          dec.illegal = 1'b0;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.ctrl    = ALU_SUB;
          dec.illegal = 1'b0;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec.ctrl    = ALU_SRA;
          dec.illegal = 1'b0;
        end
        dec.is_signed = !(dec.illegal == 1'b0 && f3 == 3'b011);
      end
      7'b0010011: begin
        dec.src_a = in_rs1_data;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.src_b = {27'b0, in_instr[24:20]};
          if (f7 == 7'b0000000) begin
            dec.ctrl    = f3_op;
            dec.illegal = 1'b0;
          end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
            dec.ctrl    = ALU_SRA;
            dec.illegal = 1'b0;
          end
        end else begin
          dec.src_b     = imm_i;
          dec.ctrl      = f3_op;
          dec.illegal   = 1'b0;
          dec.is_signed = (f3 != 3'b011);
        end
      end
      7'b0110111: begin
        dec.src_b   = imm_u;
        dec.illegal = 1'b0;
      end
      7'b0010111: begin
        dec.src_a   = in_pc;
        dec.src_b   = imm_u;
        dec.illegal = 1'b0;
      end
      7'b1100011: begin
        if (f3 != 3'b010 && f3 != 3'b011) begin
          dec.src_a     = in_rs1_data;
          dec.src_b     = in_rs2_data;
          dec.is_branch = 1'b1;
          dec.illegal   = 1'b0;
          dec.ctrl      = (f3[2] == 1'b0) ? ALU_SUB : ALU_SLT;
          dec.is_signed = (f3[2:1] != 2'b11);
        end
      end
      default: ;
    endcase
    if (dec.illegal) begin
      dec.src_a     = '0;
      dec.src_b     = '0;
      dec.ctrl      = ALU_ADD;
      dec.is_branch = 1'b0;
      dec.is_signed = 1'b1;
    end
  end

  assign load = in_valid & in_ready;

`ifdef RISC_V_MIKE_ISSUE_SKID_EN
  t_issue_beat skid_q;
  logic        skid_valid_q;
  logic        in_ready_q;
  logic        drain;

  assign drain    = !out_valid_q | out_ready;
  assign in_ready = in_ready_q;

  // in_ready_q mirrors !skid_valid_q, so a load never coincides with a full skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (skid_valid_q) begin
      if (drain) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end
    end else if (load) begin
      if (drain) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= dec;
        skid_valid_q <= 1'b1;
        in_ready_q   <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid_q | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid     = out_valid_q;
  assign alu_src_a     = out_q.src_a;
  assign alu_src_b     = out_q.src_b;
  assign alu_ctrl      = out_q.ctrl;
  assign alu_signed    = out_q.is_signed;
  assign out_is_branch = out_q.is_branch;
  assign out_funct3    = out_q.funct3;
  assign out_pc        = out_q.pc;
  assign out_illegal   = out_q.illegal;

endmodule

// File: doc/risc_v_mike_alu_issue.md
RISC_V_MIKE_ALU_ISSUE -- requirements
Module: risc_v_mike_alu_issue

Interface
REQ-001 SHALL have no parameters; all data widths are DATA_32_W (32) from risc_v_mike_pkg.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, ports as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- in_instr  in  32  RV32I instruction word.
- in_pc  in  32  instruction address.
- in_rs1_data  in  32  rs1 register value.
- in_rs2_data  in  32  rs2 register value.
- out_valid  out  1  issue beat valid.
- out_ready  in  1  ALU stage accepts.
- alu_src_a  out  32  ALU operand A.
- alu_src_b  out  32  ALU operand B.
- alu_ctrl  out  t_alu_opcode  ALU operation.
- alu_signed  out  1  signed compare select.
- out_is_branch  out  1  conditional branch.
- out_funct3  out  3  instr[14:12], passed through.
- out_pc  out  32  in_pc, passed through.
- out_illegal  out  1  undecodable instruction.

Function
REQ-003 SHALL transfer in on in_valid&in_ready, and out on out_valid&out_ready; beats are never dropped, duplicated or reordered (except under REQ-011).
REQ-004 SHALL register all outputs; latency from input transfer to out_valid is 1 cycle.
REQ-005 SHALL decode R-type (0110011): funct7=0000000, f3 000 ADD, 001 SLL, 010 SLT, 011 SLT unsigned, 100 XOR, 101 SRL, 110 OR, 111 AND; funct7=0100000, f3 000 SUB, 101 SRA; a=rs1, b=rs2.
REQ-006 SHALL decode I-type ALU (0010011) with the same f3 map, a=rs1, b=sign-extended instr[31:20]; shifts use b={27'b0,instr[24:20]} and require instr[31:25]=0000000 (SLLI, SRLI) or 0100000 (SRAI).
REQ-007 SHALL zero-extend the shift amount for R-type shifts: b={27'b0,rs2[4:0]}.
REQ-008 SHALL decode LUI (0110111) as ADD with a=0, b={instr[31:12],12'b0}; AUIPC (0010111) as ADD with a=in_pc and the same b.
REQ-009 SHALL decode branches (1100011) with out_is_branch=1, a=rs1, b=rs2: f3 000/001 SUB, 100/101 SLT signed, 110/111 SLT unsigned; f3 010/011 are illegal.
REQ-010 SHALL drive alu_signed=0 only for SLTU, SLTIU, BLTU, BGEU, otherwise 1; any other encoding SHALL give out_illegal=1, alu_ctrl=ALU_ADD, a=b=0, out_is_branch=0.
REQ-011 SHALL, on flush=1, clear out_valid and all held beats at the next edge; a beat transferred in the flush cycle is discarded.
REQ-012 SHALL hold all outputs stable while out_valid&!out_ready.

Reset
REQ-013 SHALL, while rst_n=0, force out_valid=0, in_ready=1, skid empty, all data outputs 0, alu_ctrl=ALU_ADD; transfers during reset are ignored.
REQ-014 SHALL, on rst_n asserted mid-transfer, discard all held beats immediately (asynchronously).

Configuration
REQ-015 SHALL honour RISC_V_MIKE_ISSUE_SKID_EN: defined -> a one-entry skid buffer behind the output register, in_ready registered as !skid_valid, full throughput under back-pressure; on out_ready with skid full, skid moves to output the same edge.
REQ-016 SHALL, with RISC_V_MIKE_ISSUE_SKID_EN undefined, use a single output register, in_ready = !out_valid | out_ready (combinational); function is otherwise identical.

Verification
REQ-017 SHALL pass: instr 0xFFD00093 (ADDI), rs1=5 -> next cycle out_valid=1, ALU_ADD, a=5, b=0xFFFFFFFD, alu_signed=1.
REQ-018 SHALL pass: instr 0x40415093 (SRAI 4), rs1=0x80000000 -> ALU_SRA, b=0x00000004, out_illegal=0.
REQ-019 SHALL pass: BLTU (f3 110), rs1=1, rs2=2 -> ALU_SLT, alu_signed=0, out_is_branch=1, out_funct3=110.
REQ-020 SHALL pass: instr 0x00000000 -> out_illegal=1, ALU_ADD, a=b=0.
REQ-021 SHALL pass: with SKID_EN, three back-to-back beats while out_ready=0 for 3 cycles -> beats 1-2 held, in_ready=0 from cycle 2, beat 3 stalled; releasing out_ready yields beats 1,2,3 in order on consecutive cycles.
REQ-022 SHALL pass: flush with output and skid full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, no beat emitted.
